// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: MIPS opcodes, request kinds and loader FSM states shared by encoder and decoder
package instr_encoder_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  typedef enum logic [2:0] {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_J} kind_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request handshake (in_*) and instruction-memory write port (imem_*); master drives requests, slave is the encoder
interface instr_encoder_if #(parameter int ADDR_W = 6);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational fields-to-word packer (kind/rs/rt/rd/funct/imm/target in; word and invalid-kind flag out)
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        invalid
);
  logic [5:0] op;
  always_comb begin
    op = kind == K_LW ? OP_LW : kind == K_SW ? OP_SW : kind == K_BEQ ? OP_BEQ : kind == K_ADDI ? OP_ADDI : OP_RTYPE;
    invalid = kind > K_J;
    word = kind == K_R ? {OP_RTYPE, rs, rt, rd, 5'd0, funct} :
           kind == K_J ? {OP_J, target} :
           invalid     ? 32'd0 : {op, rs, rt, imm};
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming MIPS program loader (clk/rst, start/finish pulses, bus = request + imem write port, busy/done/err/count status)
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               finish,
  instr_encoder_if.slave     bus,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    count
);
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, word;
  logic              we_q, we_d, err_q, err_d, invalid, accept, clear;
  instr_pack u_pack (
    .kind    (bus.in_kind),
    .rs      (bus.in_rs),
    .rt      (bus.in_rt),
    .rd      (bus.in_rd),
    .funct   (bus.in_funct),
    .imm     (bus.in_imm),
    .target  (bus.in_target),
    .word    (word),
    .invalid (invalid)
  );
  assign bus.in_ready   = state_q == S_LOAD && count_q != CAP;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy  = state_q == S_LOAD || state_q == S_FLUSH;
  assign done  = state_q == S_DONE;
  assign err   = err_q;
  assign count = count_q;
  always_comb begin
    accept  = bus.in_valid && bus.in_ready;
    clear   = start && (state_q == S_IDLE || state_q == S_DONE);
    state_d = clear ? S_LOAD : (state_q == S_LOAD && finish) ? S_FLUSH : state_q == S_FLUSH ? S_DONE : state_q;
    we_d    = accept && !invalid;
    // count only moves on valid writes, so it doubles as the next write address
    count_d = clear ? '0 : count_q + {{ADDR_W{1'b0}}, we_d};
    addr_d  = clear ? '0 : we_d ? count_q[ADDR_W-1:0] : addr_q;
    wdata_d = we_d ? word : wdata_q;
    err_d   = !clear && (err_q || (accept && invalid));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of instr_encoder at ADDR_W=6 and ADDR_W=2
module tb_instr_encoder;
  logic clk = 1'b0, rst = 1'b1;
  logic start_a = 1'b0, finish_a = 1'b0, start_b = 1'b0, finish_b = 1'b0;
  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [6:0] count_a;
  logic [2:0] count_b;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  instr_encoder_if #(.ADDR_W(6)) ia ();
  instr_encoder_if #(.ADDR_W(2)) ib ();
  instr_encoder #(.ADDR_W(6)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .finish(finish_a), .bus(ia),
    .busy(busy_a), .done(done_a), .err(err_a), .count(count_a)
  );
  instr_encoder #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .finish(finish_b), .bus(ib),
    .busy(busy_b), .done(done_b), .err(err_b), .count(count_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat_a(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [5:0] f, input logic [15:0] imm, input logic [25:0] t);
    ia.in_valid = 1'b1; ia.in_kind = k; ia.in_rs = rs; ia.in_rt = rt; ia.in_rd = rd;
    ia.in_funct = f; ia.in_imm = imm; ia.in_target = t;
  endtask
  task automatic end_and_restart_a();
    ia.in_valid = 1'b0; finish_a = 1'b1;
    tick();
    finish_a = 1'b0;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask
  initial begin
    ia.in_valid = 1'b0; ia.in_kind = '0; ia.in_rs = '0; ia.in_rt = '0; ia.in_rd = '0;
    ia.in_funct = '0; ia.in_imm = '0; ia.in_target = '0;
    ib.in_valid = 1'b0; ib.in_kind = '0; ib.in_rs = 5'd1; ib.in_rt = 5'd2; ib.in_rd = '0;
    ib.in_funct = 6'h20; ib.in_imm = '0; ib.in_target = '0;
    repeat (2) tick();
    chk("rst_ready", ia.in_ready, 0); chk("rst_we", ia.imem_we, 0);
    chk("rst_addr", ia.imem_addr, 0); chk("rst_wdata", ia.imem_wdata, 0);
    chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0); chk("rst_count", count_a, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", ia.in_ready, 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("load_busy", busy_a, 1); chk("load_ready", ia.in_ready, 1);
    beat_a(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0);
    tick();
    chk("r_we", ia.imem_we, 1); chk("r_addr", ia.imem_addr, 0);
    chk("r_wdata", ia.imem_wdata, 32'h00221820); chk("r_count", count_a, 1);
    end_and_restart_a();
    chk("restart_count", count_a, 0);
    beat_a(3'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0004, 26'h0);
    tick();
    chk("lw_we", ia.imem_we, 1); chk("lw_addr", ia.imem_addr, 0); chk("lw_wdata", ia.imem_wdata, 32'h8C220004);
    beat_a(3'd2, 5'd0, 5'd2, 5'd0, 6'h0, 16'h0008, 26'h0);
    tick();
    chk("sw_we", ia.imem_we, 1); chk("sw_addr", ia.imem_addr, 1); chk("sw_wdata", ia.imem_wdata, 32'hAC020008);
    beat_a(3'd3, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0);
    tick();
    chk("beq_we", ia.imem_we, 1); chk("beq_addr", ia.imem_addr, 2); chk("beq_wdata", ia.imem_wdata, 32'h1022FFFF);
    chk("b2b_count", count_a, 3);
    ia.in_valid = 1'b0;
    tick();
    chk("idle_beat_we", ia.imem_we, 0);
    end_and_restart_a();
    beat_a(3'd4, 5'd0, 5'd1, 5'd0, 6'h0, 16'h0005, 26'h0);
    tick();
    chk("addi_we", ia.imem_we, 1); chk("addi_wdata", ia.imem_wdata, 32'h20010005);
    beat_a(3'd7, 5'd3, 5'd3, 5'd3, 6'h3, 16'h3, 26'h3);
    tick();
    chk("bad_we", ia.imem_we, 0); chk("bad_err", err_a, 1);
    chk("bad_count", count_a, 1); chk("bad_addr", ia.imem_addr, 0);
    beat_a(3'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10);
    finish_a = 1'b1;
    tick();
    ia.in_valid = 1'b0; finish_a = 1'b0;
    chk("j_we", ia.imem_we, 1); chk("j_addr", ia.imem_addr, 1); chk("j_wdata", ia.imem_wdata, 32'h08000010);
    chk("flush_busy", busy_a, 1); chk("flush_ready", ia.in_ready, 0); chk("flush_done", done_a, 0);
    tick();
    chk("done_done", done_a, 1); chk("done_busy", busy_a, 0); chk("done_we", ia.imem_we, 0);
    chk("done_err", err_a, 1); chk("done_count", count_a, 2);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("restart_err", err_a, 0);
    beat_a(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0);
    tick();
    ia.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", ia.imem_we, 0); chk("mid_rst_count", count_a, 0); chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_wdata", ia.imem_wdata, 0); chk("mid_rst_ready", ia.in_ready, 0);
    tick();
    rst = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    beat_a(3'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'h0004, 26'h0);
    tick();
    ia.in_valid = 1'b0;
    chk("post_rst_we", ia.imem_we, 1); chk("post_rst_addr", ia.imem_addr, 0);
    chk("post_rst_wdata", ia.imem_wdata, 32'h8C220004);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    ib.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ib.in_rd = 5'(i);
      tick();
      chk($sformatf("full_we%0d", i), ib.imem_we, 1);
      chk($sformatf("full_addr%0d", i), ib.imem_addr, i);
      chk($sformatf("full_wdata%0d", i), ib.imem_wdata, {6'd0, 5'd1, 5'd2, 5'(i), 5'd0, 6'h20});
    end
    chk("full_ready", ib.in_ready, 0); chk("full_count", count_b, 4);
    ib.in_rd = 5'd4;
    tick();
    chk("full_held_we", ib.imem_we, 0); chk("full_held_count", count_b, 4); chk("full_held_addr", ib.imem_addr, 3);
    ib.in_valid = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming MIPS instruction encoder and program loader. Accepts field-level instruction requests (kind, registers, immediate, jump target) over a valid/ready handshake, packs them into 32-bit MIPS words, and writes them sequentially into the instruction-memory write port starting at word 0. It produces exactly the opcodes the main control decoder recognises (R-type, lw, sw, beq, addi, j). It sits in the test and bring-up path ahead of instruction memory.

## Interface
Parameters:
- ADDR_W, 6, instruction-memory word-address width; capacity 2**ADDR_W words.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a program load
- finish  in  1  pulse; ends the load after the current beat
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_kind  in  3  0=R, 1=lw, 2=sw, 3=beq, 4=addi, 5=j, 6–7 invalid
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_funct  in  6  R-type funct
- in_imm  in  16  I-type immediate
- in_target  in  26  j target
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded word
- busy  out  1  state is LOAD or FLUSH
- done  out  1  load complete
- err  out  1  sticky; an invalid kind was received this load
- count  out  ADDR_W+1  words written or pending this load

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE: in_ready=0. A start pulse moves to LOAD and clears count, err, and the write address.
- LOAD: in_ready = (count != 2**ADDR_W). A beat is accepted when in_valid && in_ready.
- Encodings (shamt is always 0):
  - R: {000000, rs, rt, rd, 00000, funct}
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - beq: {000100, rs, rt, imm}
  - addi: {001000, rs, rt, imm}
  - j: {000010, target}
- Valid accepted beat: the word goes into a one-entry output register, and count increments.
- Invalid kind: the beat is consumed, nothing is written, count is unchanged, and err is set.
- Full: when count reaches 2**ADDR_W, in_ready drops. The write address never wraps.
- finish in LOAD moves to FLUSH. A beat accepted in the same cycle is still encoded and written.
- FLUSH: lasts one cycle so the final write drains, then moves to DONE.
- DONE: done=1, in_ready=0. A start pulse re-enters LOAD and clears count and err.
- start while in LOAD or FLUSH is ignored. finish outside LOAD is ignored.

## Timing
- Reset values: state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, count=0.
- Latency: a beat accepted at edge N drives imem_we=1 with addr/wdata during cycle N+1 (registered outputs). imem_we is high for exactly one cycle per valid beat.
- Back-to-back beats give consecutive writes at consecutive addresses, with no bubbles.
- count increments on the acceptance edge.
- done asserts the cycle after FLUSH.
- Reset mid-load: everything returns to reset values immediately, and a pending write is dropped.

## Structure
- Shared package (also used by the main decoder) holds:
  - opcode constants OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_ADDI=001000, OP_J=000010
  - the in_kind enumeration
  - the FSM state encoding
- Sub-module instr_pack: purely combinational fields-to-word packer with an invalid flag. Reusable in testbenches.

## Test plan
- start; beat R rs=1 rt=2 rd=3 funct=100000 -> next cycle imem_we=1, addr=0, wdata=0x00221820.
- Back-to-back lw $2,4($1); sw $2,8($0); beq rs=1 rt=2 imm=0xFFFF -> writes at addr 0/1/2 of 0x8C220004, 0xAC020008, 0x1022FFFF on consecutive cycles; count=3.
- addi rs=0 rt=1 imm=5 followed by a kind=7 beat -> one write of 0x20010005; err=1; count=1; address not advanced.
- finish together with a j target=0x10 beat -> write 0x08000010, then FLUSH, then done=1 and busy=0.
- ADDR_W=2: five beats offered -> four writes (addr 0–3), in_ready=0 after the fourth, count=4, fifth beat held.
- rst asserted the cycle after an acceptance -> no imem_we; all outputs at reset values; a subsequent start loads from addr 0.
